// File: rtl/ifu_fetch_pkg.sv
// Shared widths, fetch FSM encodings and buffer entry layout for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int INST_WIDTH     = 32;
    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 64;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_WIDTH-1:0]  pc;
        logic [INST_WIDTH-1:0] inst;
    } buf_entry_t;

    // Memory returns a doubleword; pc[2] picks which 32-bit half holds the instruction.
    function automatic logic [INST_WIDTH-1:0] lane_select(
        input logic [MEM_DATA_WIDTH-1:0] data,
        input logic                      hi
    );
        return hi ? data[63:32] : data[31:0];
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] dword_addr(input logic [CPU_WIDTH-1:0] pc);
        return {32'h0, pc & ~32'h7};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch unit's redirect, memory and instruction channels.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic                      redirect_valid;
    logic [CPU_WIDTH-1:0]      redirect_pc;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [MEM_ADDR_WIDTH-1:0] mem_req_addr;
    logic                      mem_resp_valid;
    logic [MEM_DATA_WIDTH-1:0] mem_resp_data;
    logic                      inst_valid;
    logic                      inst_ready;
    logic [INST_WIDTH-1:0]     inst;
    logic [CPU_WIDTH-1:0]      inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
        output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
        input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/ifu_fetch_inst_buf.sv
// Synchronous FIFO of {pc, inst} entries; flush wins over push and pop.
module ifu_inst_buf
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  buf_entry_t wr_entry,
    output logic       full,
    output logic       empty,
    output buf_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    buf_entry_t       entries [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding doubleword fetch, small instruction buffer, redirect flush.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
    parameter int                   BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);

    fetch_state_e         state;
    fetch_state_e         state_n;
    logic [CPU_WIDTH-1:0] fetch_pc;
    logic [CPU_WIDTH-1:0] fetch_pc_n;
    logic [CPU_WIDTH-1:0] req_pc;
    logic                 req_fire;
    logic                 push;
    logic                 pop;
    logic                 buf_full;
    logic                 buf_empty;
    buf_entry_t           head;
    buf_entry_t           wr_entry;

    // Redirect suppresses issue combinationally so a stale-PC request never leaves.
    assign bus.mem_req_valid = !rst && (state == S_REQ) && !buf_full && !bus.redirect_valid;
    assign bus.mem_req_addr  = dword_addr(fetch_pc);
    assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

    assign bus.inst_valid = !rst && !buf_empty;
    assign bus.inst       = bus.inst_valid ? head.inst : '0;
    assign bus.inst_pc    = bus.inst_valid ? head.pc   : '0;
    assign pop            = bus.inst_valid && bus.inst_ready;

    assign wr_entry = '{pc: req_pc, inst: lane_select(bus.mem_resp_data, req_pc[2])};

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        push       = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_n = bus.redirect_pc & ~32'h3;
            case (state)
                S_REQ:         state_n = S_REQ;
                S_WAIT,
                S_DROP:        state_n = bus.mem_resp_valid ? S_REQ : S_DROP;
                default:       state_n = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        push       = 1'b1;
                        fetch_pc_n = req_pc + 32'd4;
                        state_n    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.mem_resp_valid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
        end
    end

    // PC of the single outstanding request; only read while S_WAIT.
    always_ff @(posedge clk) begin
        if (req_fire) req_pc <= fetch_pc;
    end

    ifu_inst_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .wr_entry (wr_entry),
        .full     (buf_full),
        .empty    (buf_empty),
        .head     (head)
    );

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle decode/execute core (ctrl, imm_gen, reg_file, alu).
- Owns the sequential fetch PC and issues one word fetch at a time to instruction memory over a valid/ready request channel with a separate response channel.
- Buffers returned instructions in a small FIFO and presents them, with their PC, to the core over a valid/ready handshake.
- Core branch/jump outcomes come back as a redirect that flushes the buffer and squashes any in-flight response.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset.
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
redirect_valid  in  1  core requests PC change (taken branch/jump)
redirect_pc  in  32  new fetch target
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  64  request byte address, {32'h0, fetch_pc[31:3], 3'b000}
mem_resp_valid  in  1  response data valid (exactly one per accepted request, >=1 cycle later)
mem_resp_data  in  64  doubleword read data
inst_valid  out  1  buffer head valid
inst_ready  in  1  core consumes head
inst  out  32  head instruction
inst_pc  out  32  PC of head instruction

Behaviour:
- Reset: fetch_pc=RESET_PC, state=S_REQ, buffer empty (count=0, rd/wr ptr=0). Outputs in the reset cycle: mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- Request issue:
  - mem_req_valid=1 iff state==S_REQ and count<BUF_DEPTH and !redirect_valid.
  - First request is visible the cycle after rst deasserts.
  - At most one outstanding request.
- FSM states:
  - S_REQ: on req valid&ready, latch req_pc=fetch_pc, then go to S_WAIT.
  - S_WAIT: on mem_resp_valid, push {lane-selected word, req_pc} into the buffer, set fetch_pc=req_pc+4, go to S_REQ.
  - S_DROP: on mem_resp_valid, discard the data and go to S_REQ.
- Lane select: req_pc[2]=1 selects mem_resp_data[63:32]; otherwise [31:0].
- Output: inst_valid=(count!=0). inst/inst_pc come from the head entry and hold stable while inst_valid && !inst_ready. Pop on inst_valid&&inst_ready.
- Redirect has priority over all other events in its cycle:
  - Buffer flushed (count=0, pointers=0); no pop is counted.
  - fetch_pc=redirect_pc with bits[1:0] forced to 0.
  - S_REQ: next state S_REQ. No request is issued that cycle.
  - S_WAIT without mem_resp_valid: go to S_DROP.
  - S_WAIT with mem_resp_valid the same cycle: response discarded, go to S_REQ.
  - S_DROP: stay in S_DROP, or go to S_REQ if mem_resp_valid the same cycle.
  - inst_valid is 0 the cycle after a redirect.
- Simultaneous push and pop: count unchanged, legal at any count.
- Push with count==BUF_DEPTH cannot occur, because issue is gated by count<BUF_DEPTH. The bench asserts this.
- PC arithmetic is 32-bit and wraps modulo 2^32: 32'hFFFF_FFFC+4 gives 0.
- rst asserted mid-operation (S_WAIT/S_DROP) returns to reset state. Memory must also be reset, so no stale response arrives after reset.
- Latency with a zero-wait memory (ready=1, response next cycle): 2 cycles from request to inst_valid. Steady state is 1 instruction per 2 cycles.

Decomposition:
- Shared defines file (rvseed_defines.v): CPU_WIDTH (32), INST_WIDTH (32), MEM_DATA_WIDTH (64), MEM_ADDR_WIDTH (64), and fetch FSM state encodings S_REQ/S_WAIT/S_DROP.
- One sub-module: ifu_inst_buf, a synchronous FIFO of {pc, inst} entries.
  - Ports: push, pop, flush, full, empty, head.
  - Flush has priority over push and pop.

Test Plan:
- Reset then free-running, zero-wait memory returning 64'h0000_0093_0000_0013 for every request, inst_ready=1 -> requests to addrs 0x8000_0000, 0x8000_0000, 0x8000_0008. inst/inst_pc sequence is 0x13@0x8000_0000, 0x93@0x8000_0004, 0x13@0x8000_0008.
- inst_ready=0 held -> exactly BUF_DEPTH=2 responses are buffered, then mem_req_valid stays 0. Release ready -> both entries drain in order and fetching resumes at 0x8000_0008.
- Redirect to 0x8000_0100 while in S_WAIT (memory delays the response by 3 cycles) -> stale response dropped, buffer empty. Next request addr is 0x8000_0100 and the first delivered inst_pc is 0x8000_0100.
- Redirect in the same cycle as mem_resp_valid -> data not pushed. Next cycle state is S_REQ with fetch_pc = redirect target.
- mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stay stable throughout, and no state advance occurs.
- rst pulsed while in S_WAIT with 1 entry buffered -> the following cycle has inst_valid=0 and fetch restarts at RESET_PC.
